// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - memory-access stage controller for the 8-bit pipelined CPU
//
// Takes the EXE/MEM bundle and either passes it to WB after one cycle
// (non-memory ops) or runs a req/ack data-memory access. While the access
// runs it stalls the upstream stages. A bounded wait turns a hung memory
// into a sticky error.
//
// Parameters:
//   TIMEOUT        WAIT cycles without ack before the access is abandoned (1..255)
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   regWr_IN, memWr_IN, memRd_IN, aluRes_IN, memWrData_IN, rd_IN
//                  EXE/MEM bundle
//   stall_OUT      combinational hold request to PC, IF/ID, ID/EXE, EXE/MEM
//   dmemReq_OUT, dmemWe_OUT, dmemAddr_OUT, dmemWData_OUT
//                  registered data-memory request
//   dmemAck_IN, dmemRData_IN
//                  memory completion and load data (same cycle)
//   regWr_OUT, rd_OUT, wbData_OUT
//                  registered write-back bundle
//   memErr_OUT     sticky timeout or protocol error, cleared only by rst
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       regWr_IN,
    input  logic       memWr_IN,
    input  logic       memRd_IN,
    input  logic [7:0] aluRes_IN,
    input  logic [7:0] memWrData_IN,
    input  logic [2:0] rd_IN,
    output logic       stall_OUT,
    output logic       dmemReq_OUT,
    output logic       dmemWe_OUT,
    output logic [7:0] dmemAddr_OUT,
    output logic [7:0] dmemWData_OUT,
    input  logic       dmemAck_IN,
    input  logic [7:0] dmemRData_IN,
    output logic       regWr_OUT,
    output logic [2:0] rd_OUT,
    output logic [7:0] wbData_OUT,
    output logic       memErr_OUT
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Counter value seen in the last permitted WAIT cycle.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_next;

    logic       issue;
    logic       complete;
    logic       abandon;

    logic [7:0] wait_cnt;
    logic       cap_regwr;
    logic [2:0] cap_rd;
    logic [7:0] cap_alu;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Stall depends only on state, the request strobes and ack, never on read data.
    always_comb begin
        state_next = state;
        stall_OUT  = 1'b0;
        issue      = 1'b0;
        complete   = 1'b0;
        abandon    = 1'b0;
        case (state)
            IDLE: begin
                if (memRd_IN || memWr_IN) begin
                    stall_OUT  = 1'b1;
                    issue      = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (dmemAck_IN) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end else begin
                    stall_OUT = 1'b1;
                    if (wait_cnt == CNT_LAST) begin
                        abandon    = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmemReq_OUT   <= 1'b0;
            dmemWe_OUT    <= 1'b0;
            dmemAddr_OUT  <= 8'h00;
            dmemWData_OUT <= 8'h00;
            regWr_OUT     <= 1'b0;
            rd_OUT        <= 3'd0;
            wbData_OUT    <= 8'h00;
            memErr_OUT    <= 1'b0;
            wait_cnt      <= 8'h00;
            cap_regwr     <= 1'b0;
            cap_rd        <= 3'd0;
            cap_alu       <= 8'h00;
        end else if (issue) begin
            // A simultaneous load+store request is resolved as a store.
            dmemReq_OUT   <= 1'b1;
            dmemWe_OUT    <= memWr_IN;
            dmemAddr_OUT  <= aluRes_IN;
            dmemWData_OUT <= memWrData_IN;
            cap_regwr     <= regWr_IN;
            cap_rd        <= rd_IN;
            cap_alu       <= aluRes_IN;
            wait_cnt      <= 8'h00;
            regWr_OUT     <= 1'b0;
            if (memRd_IN && memWr_IN) begin
                memErr_OUT <= 1'b1;
            end
        end else if (complete) begin
            dmemReq_OUT <= 1'b0;
            regWr_OUT   <= cap_regwr;
            rd_OUT      <= cap_rd;
            // dmemWe_OUT still holds the access type of the finishing request.
            wbData_OUT  <= dmemWe_OUT ? cap_alu : dmemRData_IN;
        end else if (abandon) begin
            dmemReq_OUT <= 1'b0;
            memErr_OUT  <= 1'b1;
            regWr_OUT   <= 1'b0;
        end else if (state == WAIT) begin
            wait_cnt  <= wait_cnt + 8'd1;
            regWr_OUT <= 1'b0;
        end else begin
            regWr_OUT  <= regWr_IN;
            rd_OUT     <= rd_IN;
            wbData_OUT <= aluRes_IN;
        end
    end

endmodule
